dpm_port_arbiter: RTL and testbench
===================================

# dpm_port_arbiter

Round-robin arbiter that shares one port of the dual-port memory between N_REQ requesters on a single clock domain. It accepts requests over a valid/ready handshake and drives the memory port's enable, write-enable, address and data. It tracks issued reads through a tag pipeline matched to the memory read latency, and routes returned read data back to the requester that issued the read. It sits between client logic and port A or port B of the memory, running on that port's clock.

## Interface
- WIDTH, 8, data width; matches memory WIDTH
- ADDR_WIDTH, 4, address width; matches memory ADDR_WIDTH
- N_REQ, 4, number of requesters; range 2..16
- MEM_RD_LAT, 1, clock edges from the issue edge until i_mem_dout holds read data; range 1..8; equals max(READ_LATENCY,1) of the attached port
- IDX_W, $clog2(N_REQ), requester index width (derived)

Ports:
- i_clk  in  1  clock; the same clock as the attached memory port
- i_rst  in  1  synchronous, active-high reset
- i_req_valid  in  N_REQ  per-requester request valid
- i_req_we  in  N_REQ  per-requester: 1 = write, 0 = read
- i_req_addr  in  N_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- i_req_wdata  in  N_REQ*WIDTH  packed write data
- o_req_ready  out  N_REQ  one-hot or zero; the handshake completes when valid&ready
- o_rsp_valid  out  N_REQ  one-hot single-cycle read-response strobe
- o_rsp_data  out  WIDTH  read data; qualified by o_rsp_valid
- o_mem_en  out  1  memory enable
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_WIDTH  memory address
- o_mem_din  out  WIDTH  memory write data
- i_mem_dout  in  WIDTH  memory read data
- o_rd_inflight  out  4  count of issued reads not yet responded (saturating not required; max MEM_RD_LAT+1)

## Operation
- Grant is combinational from i_req_valid and the round-robin pointer `ptr`. The grant goes to the first valid requester at or after `ptr`, searching ascending with modulo N_REQ wrap.
- o_req_ready is asserted only for the granted requester. No requester is ready when no request is valid. Ready never depends on other ports.
- Memory outputs are combinational from the granted request:
  - o_mem_en = |i_req_valid
  - o_mem_we, o_mem_addr and o_mem_din come from the granted requester
  - when no grant: o_mem_en = 0, o_mem_we = 0, and addr/din are 0
- At a handshake edge:
  - `ptr` <= grant index + 1, modulo N_REQ
  - `ptr` is unchanged when there is no grant
- Tag pipeline: MEM_RD_LAT+1 stages, each holding {rd, idx}. Stage 0 loads {handshake & ~we, grant idx} every edge.
- When the last stage has rd = 1:
  - o_rsp_data <= i_mem_dout, sampled at that edge
  - o_rsp_valid <= onehot(idx) for exactly one cycle
  - otherwise o_rsp_valid <= 0 and o_rsp_data holds its value
- Writes produce no response.
- Throughput: one request per cycle, with reads fully pipelined. There is no backpressure on responses; requesters must accept o_rsp_valid unconditionally.
- Ordering:
  - responses return in issue order
  - read-after-write to the same address through this arbiter is coherent only when the attached port's WRITE_LATENCY is 0
- o_rd_inflight increments on a read handshake and decrements on an o_rsp_valid cycle. When both happen in the same cycle it is unchanged.

## Timing
- Reset (i_rst = 1 at an edge) clears:
  - `ptr` = 0
  - all tag stages rd = 0
  - o_rsp_valid = 0, o_rsp_data = 0, o_rd_inflight = 0
- The combinational memory outputs follow the inputs even during reset. Requesters must hold valid low during reset.
- Reset mid-operation drops all in-flight reads: no responses are produced for them, and memory contents are unaffected.
- Read latency: a handshake at edge k gives o_rsp_valid high in the cycle after edge k+MEM_RD_LAT+1, i.e. MEM_RD_LAT+1 cycles after the handshake edge.
- Handshake to memory: zero added cycles. The request is presented to the memory in the same cycle it is granted.
- Simultaneous requests: exactly one is granted per cycle; losers hold their requests stable until granted.
- Fairness: a continuously valid requester is granted within N_REQ cycles.

## Configuration
- DPM_ARB_PRIO0_EN defined:
  - requester 0 has fixed absolute priority; when i_req_valid[0] = 1 it is always granted and `ptr` is unchanged
  - requesters 1..N_REQ-1 share round-robin among themselves, with `ptr` ranging over 1..N_REQ-1 and reset value 1
  - requesters 1..N_REQ-1 may starve while requester 0 is continuously valid
- Undefined (default): pure round-robin over all N_REQ requesters as above.

## Test plan
- Single read: req 2 reads addr 5 (mem[5] = 8'hA5), MEM_RD_LAT = 1 -> o_req_ready[2] in the same cycle; o_rsp_valid = 4'b0100 and o_rsp_data = 8'hA5 exactly 2 cycles after the handshake; o_rd_inflight goes 0 -> 1 -> 0.
- Round-robin: all 4 requesters valid continuously for 8 cycles from reset -> grant sequence 0,1,2,3,0,1,2,3.
- Mixed pipelined traffic: req 0 writes 8'h3C to addr 7, then req 1 reads addr 7 back-to-back (WRITE_LATENCY 0, MEM_RD_LAT = 2) -> req 1 receives 8'h3C, 3 cycles after its handshake; no response to req 0.
- Reset mid-flight: issue reads on 3 consecutive cycles, assert i_rst on the next edge -> no o_rsp_valid ever, o_rd_inflight = 0, `ptr` = 0.
- Idle: no valid -> o_mem_en = 0, o_req_ready = 0, and `ptr` unchanged over 10 cycles.
- With DPM_ARB_PRIO0_EN: reqs 0,1,2 valid; req 0 drops after 3 cycles -> grants 0,0,0,1,2,1.

Source files
------------

// File: rtl/dpm_port_arbiter.sv
// Round-robin arbiter sharing one dual-port-memory port between N_REQ requesters.
// Latency: request reaches the memory in the grant cycle; read response MEM_RD_LAT+1 cycles after handshake.
// Backpressure: only the granted requester sees ready; responses cannot be stalled.
//
// Ports:
//   i_clk, i_rst                    clock (same as memory port) and synchronous active-high reset
//   i_req_valid/we/addr/wdata       per-requester request, packed by requester index
//   o_req_ready                     one-hot grant, completes the handshake with i_req_valid
//   o_rsp_valid, o_rsp_data         one-hot single-cycle read response strobe and its data
//   o_mem_en/we/addr/din, i_mem_dout  memory port
//   o_rd_inflight                   reads issued but not yet presented on o_rsp_valid
//
// Optional build macro DPM_ARB_PRIO0_EN: requester 0 gets absolute priority and the
// round-robin pointer only rotates over requesters 1..N_REQ-1.
module dpm_port_arbiter #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int N_REQ      = 4,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_REQ-1:0]            i_req_valid,
    input  logic [N_REQ-1:0]            i_req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [N_REQ*WIDTH-1:0]      i_req_wdata,
    output logic [N_REQ-1:0]            o_req_ready,
    output logic [N_REQ-1:0]            o_rsp_valid,
    output logic [WIDTH-1:0]            o_rsp_data,
    output logic                        o_mem_en,
    output logic                        o_mem_we,
    output logic [ADDR_WIDTH-1:0]       o_mem_addr,
    output logic [WIDTH-1:0]            o_mem_din,
    input  logic [WIDTH-1:0]            i_mem_dout,
    output logic [3:0]                  o_rd_inflight
);

    localparam int IDX_W = $clog2(N_REQ);

`ifdef DPM_ARB_PRIO0_EN
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(1);
`else
    localparam logic [IDX_W-1:0] PTR_RST = '0;
`endif

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic [IDX_W-1:0] cand_idx;
    int               cand;

    // Tag pipeline: stage s holds whether the request issued s+1 edges ago was a read.
    logic [MEM_RD_LAT:0]            tag_rd;
    logic [MEM_RD_LAT:0][IDX_W-1:0] tag_idx;

    logic rd_hs;
    logic rsp_fire;

    // Grant search: first valid requester at or after ptr, wrapping.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        cand     = 0;
        cand_idx = '0;
`ifdef DPM_ARB_PRIO0_EN
        if (i_req_valid[0]) begin
            gnt_vld = 1'b1;
        end else begin
            // ptr lives in 1..N_REQ-1, so the wrap skips requester 0.
            for (int k = 0; k < N_REQ - 1; k++) begin
                cand = int'(ptr) + k;
                if (cand >= N_REQ) begin
                    cand = cand - (N_REQ - 1);
                end
                cand_idx = IDX_W'(cand);
                if (!gnt_vld && i_req_valid[cand_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand_idx;
                end
            end
        end
`else
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!gnt_vld && i_req_valid[cand_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand_idx;
            end
        end
`endif
    end

    // Ready is only raised towards a valid requester, so a grant is always a handshake.
    always_comb begin
        o_req_ready = '0;
        if (gnt_vld) begin
            o_req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        o_mem_en   = |i_req_valid;
        o_mem_we   = 1'b0;
        o_mem_addr = '0;
        o_mem_din  = '0;
        if (gnt_vld) begin
            o_mem_we   = i_req_we[gnt_idx];
            o_mem_addr = i_req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            o_mem_din  = i_req_wdata[gnt_idx*WIDTH +: WIDTH];
        end
    end

    assign rd_hs    = gnt_vld & ~i_req_we[gnt_idx];
    // The inflight count drops on the same edge that raises o_rsp_valid, so a
    // read is no longer counted during the cycle its data is presented.
    assign rsp_fire = tag_rd[MEM_RD_LAT];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr           <= PTR_RST;
            tag_rd        <= '0;
            tag_idx       <= '0;
            o_rsp_valid   <= '0;
            o_rsp_data    <= '0;
            o_rd_inflight <= '0;
        end else begin
`ifdef DPM_ARB_PRIO0_EN
            if (gnt_vld && (gnt_idx != '0)) begin
                ptr <= (int'(gnt_idx) == N_REQ - 1) ? IDX_W'(1) : gnt_idx + IDX_W'(1);
            end
`else
            if (gnt_vld) begin
                ptr <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + IDX_W'(1);
            end
`endif
            tag_rd[0]  <= rd_hs;
            tag_idx[0] <= gnt_idx;
            for (int s = 1; s <= MEM_RD_LAT; s++) begin
                tag_rd[s]  <= tag_rd[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end

            if (rsp_fire) begin
                o_rsp_valid <= N_REQ'(1) << tag_idx[MEM_RD_LAT];
                o_rsp_data  <= i_mem_dout;
            end else begin
                o_rsp_valid <= '0;
            end

            case ({rd_hs, rsp_fire})
                2'b10:   o_rd_inflight <= o_rd_inflight + 4'd1;
                2'b01:   o_rd_inflight <= o_rd_inflight - 4'd1;
                default: o_rd_inflight <= o_rd_inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_dpm_port_arbiter.sv
// Bench for dpm_port_arbiter: directed vectors, reads scored through a response queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_dpm_port_arbiter;

    localparam int W   = 8;
    localparam int AW  = 4;
    localparam int N   = 4;
    localparam int LAT = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*W-1:0] req_wdata;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           mem_en;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [W-1:0]   mem_din;
    logic [W-1:0]   mem_dout;
    logic [3:0]     rd_inflight;

    always #5 clk = ~clk;

    dpm_port_arbiter #(
        .WIDTH(W), .ADDR_WIDTH(AW), .N_REQ(N), .MEM_RD_LAT(LAT)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_req_ready(req_ready),
        .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
        .o_mem_en(mem_en), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_din(mem_din),
        .i_mem_dout(mem_dout),
        .o_rd_inflight(rd_inflight)
    );

    // Memory model: write lands at the issue edge; read data holds on dout
    // from LAT edges after the issue edge.
    logic [W-1:0] mem [16];
    logic [W-1:0] rd_pipe [LAT+1];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_din;
        rd_pipe[0] <= mem[mem_addr];
        for (int i = 1; i <= LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_dout = rd_pipe[LAT];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [N-1:0] vld;
        logic [W-1:0] dat;
        int           at;
    } rsp_t;
    rsp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called in the cycle a read is granted, before its handshake edge.
    task automatic push_rd(input logic [N-1:0] oh, input logic [W-1:0] d);
        rsp_t e;
        e.vld = oh;
        e.dat = d;
        e.at  = cyc + LAT + 2;
        sb.push_back(e);
    endtask

    // Response monitor.
    always @(negedge clk) begin
        rsp_t e;
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'(e.vld));
                check("rsp_data", 32'(rsp_data), 32'(e.dat));
                check("rsp_cycle", cyc, e.at);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
        req_valid[i]            = 1'b1;
        req_we[i]               = we;
        req_addr[i*AW +: AW]    = a;
        req_wdata[i*W +: W]     = d;
    endtask

    int exp_rr [8];
    logic [N-1:0] exp_after_idle;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 16; a++) mem[a] = 8'hA0 | 8'(a);
`ifdef DPM_ARB_PRIO0_EN
        exp_rr         = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_after_idle = 4'b0001;
`else
        exp_rr         = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_after_idle = 4'b0010;
`endif
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        step();
        step();
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_inflight", 32'(rd_inflight), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;

        // Single read: requester 2 reads addr 5.
        set_req(2, 1'b0, 4'd5, 8'h00);
        @(negedge clk);
        check("rd_ready", 32'(req_ready), 32'b0100);
        check("rd_mem_en", 32'(mem_en), 32'd1);
        check("rd_mem_we", 32'(mem_we), 32'd0);
        check("rd_mem_addr", 32'(mem_addr), 32'd5);
        push_rd(4'b0100, 8'hA5);
        step();
        req_valid = '0;
        @(negedge clk);
        check("rd_inflight_1a", 32'(rd_inflight), 32'd1);
        step();
        step();
        @(negedge clk);
        check("rd_inflight_1b", 32'(rd_inflight), 32'd1);
        step();
        @(negedge clk);
        check("rd_inflight_0", 32'(rd_inflight), 32'd0);
        step();

        // Write then back-to-back read of the same address.
        set_req(0, 1'b1, 4'd7, 8'h3C);
        @(negedge clk);
        check("wr_ready", 32'(req_ready), 32'b0001);
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_addr", 32'(mem_addr), 32'd7);
        check("wr_mem_din", 32'(mem_din), 32'h3C);
        step();
        req_valid = '0;
        set_req(1, 1'b0, 4'd7, 8'h00);
        @(negedge clk);
        check("raw_ready", 32'(req_ready), 32'b0010);
        check("raw_mem_we", 32'(mem_we), 32'd0);
        push_rd(4'b0010, 8'h3C);
        step();
        req_valid = '0;
        repeat (5) step();

        // Round-robin from reset with all requesters reading continuously.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), 8'h00);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("rr_grant%0d", c), 32'(req_ready), 32'(1) << exp_rr[c]);
            push_rd(N'(1) << exp_rr[c], 8'hA0 | 8'(exp_rr[c]));
            step();
        end
        req_valid = '0;
        @(negedge clk);
        check("rr_inflight_full", 32'(rd_inflight), 32'(LAT + 1));
        repeat (3) step();
        @(negedge clk);
        check("rr_inflight_drained", 32'(rd_inflight), 32'd0);
        repeat (2) step();

        // Reset while three reads are in flight: none may come back.
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), 8'h00);
        repeat (3) step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_inflight", 32'(rd_inflight), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (6) step();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 4'd0, 8'h00);
        @(negedge clk);
        check("midrst_ptr_grant", 32'(req_ready), 32'b0001);
        push_rd(4'b0001, 8'hA0);
        step();
        req_valid = '0;

        // Idle: nothing presented, pointer must hold.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("idle_mem_en%0d", c), 32'(mem_en), 32'd0);
            check($sformatf("idle_ready%0d", c), 32'(req_ready), 32'd0);
            step();
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'd15, 8'h55);
        @(negedge clk);
        check("idle_ptr_grant", 32'(req_ready), 32'(exp_after_idle));
        check("idle_mem_din", 32'(mem_din), 32'h55);
        step();
        req_valid = '0;
        repeat (5) step();

`ifdef DPM_ARB_PRIO0_EN
        begin
            int exp_p [6];
            exp_p = '{0, 0, 0, 1, 2, 1};
            rst = 1'b1;
            step();
            rst = 1'b0;
            for (int i = 0; i < 3; i++) set_req(i, 1'b1, 4'd15, 8'h11);
            for (int c = 0; c < 6; c++) begin
                if (c == 3) req_valid[0] = 1'b0;
                @(negedge clk);
                check($sformatf("prio_grant%0d", c), 32'(req_ready), 32'(1) << exp_p[c]);
                step();
            end
            req_valid = '0;
            repeat (3) step();
        end
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
